// File: rtl/column_output_accumulator_pkg.sv
// Shared types and saturating arithmetic helpers for the column output accumulator.
// Helpers work on a 64-bit signed carrier and clamp to a caller-given width.
package column_output_accumulator_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  localparam int WIDE = 64;

  function automatic logic signed [WIDE-1:0] sat_to_width(input logic signed [WIDE-1:0] value,
                                                          input int width);
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Operands must already be sign-extended; widths up to 62 bits cannot overflow the carrier.
  function automatic logic signed [WIDE-1:0] sat_add(input logic signed [WIDE-1:0] a,
                                                     input logic signed [WIDE-1:0] b,
                                                     input int width);
    return sat_to_width(a + b, width);
  endfunction

endpackage

// File: rtl/column_output_accumulator_sync_fifo.sv
// Synchronous FIFO with occupancy count; depth must be a power of two.
// Memory is not reset, only pointers and count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/column_output_accumulator.sv
// Accumulates one systolic column's psums across K-tiles and requantizes the last tile
// through a two-register pipeline (sum, post-process) into a small output FIFO.
module column_output_accumulator
  import column_output_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH             = 8,
  parameter int ACCUMULATOR_DATA_WIDTH = 32,
  parameter int DEPTH                  = 16,
  parameter int FIFO_DEPTH             = 4,
  parameter int SHIFT_WIDTH            = 5
) (
  input  logic                                     CLK,
  input  logic                                     SYNC_RST,
  input  logic                                     EN,
  input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] PsumIn,
  input  logic                                     PsumValid,
  output logic                                     PsumReady,
  input  logic                                     FirstTile,
  input  logic                                     LastTile,
  input  logic                                     ReluEn,
  input  logic [SHIFT_WIDTH-1:0]                   Shift,
  output logic signed [DATA_WIDTH-1:0]             OutData,
  output logic                                     OutValid,
  input  logic                                     OutReady,
  output logic                                     TileDone,
  output logic                                     Busy
);

  localparam int ACC_W = ACCUMULATOR_DATA_WIDTH;
  localparam int ROW_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                   state, state_nxt;
  logic [ROW_W-1:0]         row_idx;
  logic                     first_q, last_q, relu_q;
  logic [SHIFT_WIDTH-1:0]   shift_q;
  logic signed [ACC_W-1:0]  acc_mem [DEPTH];

  logic                     sum_valid;
  logic signed [ACC_W-1:0]  sum_q;
  logic                     pp_valid;
  logic [DATA_WIDTH-1:0]    pp_data;
  logic                     tile_done_q;

  logic                     accept, last_beat, eff_first, eff_last;
  logic signed [WIDE-1:0]   psum_ext, old_ext, sum_ext_q, pp_shifted;
  logic signed [ACC_W-1:0]  sum_acc;
  logic [DATA_WIDTH-1:0]    pp_next;

  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]    fifo_out;
  logic [CNT_W-1:0]         fifo_count;
  logic [CNT_W:0]           in_flight;

  // Everything already committed to the output path counts against FIFO room, so nothing can be dropped.
  assign in_flight = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pp_valid} + {{CNT_W{1'b0}}, sum_valid};
  assign PsumReady = !SYNC_RST && EN && (state != DRAIN) && !fifo_full &&
                     (in_flight < (CNT_W + 1)'(FIFO_DEPTH));
  assign accept    = PsumValid && PsumReady;
  assign last_beat = (row_idx == ROW_W'(DEPTH - 1));
  assign eff_first = (state == IDLE) ? FirstTile : first_q;
  assign eff_last  = (state == IDLE) ? LastTile  : last_q;

  assign psum_ext  = {{(WIDE - ACC_W){PsumIn[ACC_W-1]}}, PsumIn};
  assign old_ext   = {{(WIDE - ACC_W){acc_mem[row_idx][ACC_W-1]}}, acc_mem[row_idx]};
  assign sum_ext_q = {{(WIDE - ACC_W){sum_q[ACC_W-1]}}, sum_q};
  assign sum_acc   = eff_first ? PsumIn : ACC_W'(sat_add(old_ext, psum_ext, ACC_W));

  always_comb begin
    pp_shifted = sum_ext_q >>> shift_q;
    if (relu_q && (pp_shifted < 0)) pp_shifted = '0;
    pp_next = DATA_WIDTH'(sat_to_width(pp_shifted, DATA_WIDTH));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCUM;
      ACCUM:   if (accept && last_beat) state_nxt = last_q ? DRAIN : IDLE;
      DRAIN:   if (!sum_valid && !pp_valid && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      state       <= IDLE;
      row_idx     <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      sum_valid   <= 1'b0;
      sum_q       <= '0;
      pp_valid    <= 1'b0;
      pp_data     <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      tile_done_q <= accept && last_beat;
      if (accept) begin
        row_idx <= last_beat ? '0 : row_idx + ROW_W'(1);
        if (state == IDLE) begin
          first_q <= FirstTile;
          last_q  <= LastTile;
          relu_q  <= ReluEn;
          shift_q <= Shift;
        end
      end
      if (EN) begin
        sum_valid <= accept && eff_last;
        sum_q     <= sum_acc;
        pp_valid  <= sum_valid;
        pp_data   <= pp_next;
      end
    end
  end

  // Last-tile sums bypass the buffer, so entries keep their prior-tile values.
  always_ff @(posedge CLK) begin
    if (accept && !eff_last) acc_mem[row_idx] <= sum_acc;
  end

  assign fifo_push = pp_valid && EN;
  assign fifo_pop  = OutValid && OutReady;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (CLK),
    .rst       (SYNC_RST),
    .push      (fifo_push),
    .push_data (pp_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign OutValid = !fifo_empty;
  assign OutData  = fifo_empty ? '0 : fifo_out;
  assign TileDone = tile_done_q;
  assign Busy     = (state == ACCUM) || (state == DRAIN);

endmodule
